// File: rtl/ahb_slave_mem_arb_if.sv
// ahb_slave_mem_arb_if: bundles both requester ports and the shared single-port RAM port.
interface ahb_slave_mem_arb_if #(
   parameter int ADDR_BITS = 24,
   parameter int DATA_BITS = 32
);
   localparam int BW = DATA_BITS / 8;
   logic                 m0_req, m0_lock, m0_wr, m0_gnt, m0_rvalid;
   logic [ADDR_BITS-1:0] m0_addr;
   logic [BW-1:0]        m0_bsel;
   logic [DATA_BITS-1:0] m0_din, m0_dout;
   logic                 m1_req, m1_lock, m1_wr, m1_gnt, m1_rvalid;
   logic [ADDR_BITS-1:0] m1_addr;
   logic [BW-1:0]        m1_bsel;
   logic [DATA_BITS-1:0] m1_din, m1_dout;
   logic                 WR, RD;
   logic [ADDR_BITS-1:0] ADDR_WR, ADDR_RD;
   logic [BW-1:0]        BSEL;
   logic [DATA_BITS-1:0] DIN, DOUT;
   modport slave (
      input  m0_req, m0_lock, m0_wr, m0_addr, m0_bsel, m0_din,
      input  m1_req, m1_lock, m1_wr, m1_addr, m1_bsel, m1_din, DOUT,
      output m0_gnt, m0_rvalid, m0_dout, m1_gnt, m1_rvalid, m1_dout,
      output WR, RD, ADDR_WR, ADDR_RD, BSEL, DIN
   );
   modport master (
      output m0_req, m0_lock, m0_wr, m0_addr, m0_bsel, m0_din,
      output m1_req, m1_lock, m1_wr, m1_addr, m1_bsel, m1_din, DOUT,
      input  m0_gnt, m0_rvalid, m0_dout, m1_gnt, m1_rvalid, m1_dout,
      input  WR, RD, ADDR_WR, ADDR_RD, BSEL, DIN
   );
endinterface

// File: rtl/ahb_slave_mem_arb.sv
// ahb_slave_mem_arb: round-robin arbiter of two requesters onto one single-port RAM,
// with lock-based burst tenure capped at MAX_HOLD accesses while the other port waits.
module ahb_slave_mem_arb #(
   parameter int ADDR_BITS = 24,
   parameter int DATA_BITS = 32,
   parameter int MAX_HOLD  = 16
) (
   input logic clk,
   input logic reset,
   ahb_slave_mem_arb_if.slave bus
);
   localparam int BW = DATA_BITS / 8;
   localparam int HW = $clog2(MAX_HOLD + 1) + 1;
   localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
   state_t               state, nxt;
   logic [1:0]           req, lock, wr, gnt, rvalid;
   logic [ADDR_BITS-1:0] addr [2];
   logic [BW-1:0]        bsel [2];
   logic [DATA_BITS-1:0] din  [2];
   logic [HW-1:0]        hold_cnt, nxt_hold;
   logic                 last_owner, nxt_last, cur, own, acc, wr_s, rd_s;
   assign req     = {bus.m1_req,  bus.m0_req};
   assign lock    = {bus.m1_lock, bus.m0_lock};
   assign wr      = {bus.m1_wr,   bus.m0_wr};
   assign addr[0] = bus.m0_addr;
   assign addr[1] = bus.m1_addr;
   assign bsel[0] = bus.m0_bsel;
   assign bsel[1] = bus.m1_bsel;
   assign din[0]  = bus.m0_din;
   assign din[1]  = bus.m1_din;
   assign own  = state != IDLE;
   assign cur  = state == OWN1;
   assign acc  = own & req[cur];
   assign wr_s = acc & wr[cur];
   assign rd_s = acc & ~wr[cur];
   assign bus.WR        = wr_s;
   assign bus.RD        = rd_s;
   assign bus.ADDR_WR   = wr_s ? addr[cur] : '0;
   assign bus.ADDR_RD   = rd_s ? addr[cur] : '0;
   assign bus.BSEL      = wr_s ? bsel[cur] : '0;
   assign bus.DIN       = wr_s ? din[cur] : '0;
   assign bus.m0_gnt    = gnt[0];
   assign bus.m1_gnt    = gnt[1];
   assign bus.m0_rvalid = rvalid[0];
   assign bus.m1_rvalid = rvalid[1];
   assign bus.m0_dout   = rvalid[0] ? bus.DOUT : '0;
   assign bus.m1_dout   = rvalid[1] ? bus.DOUT : '0;
   always_comb begin
      nxt      = state;
      nxt_hold = hold_cnt;
      nxt_last = last_owner;
      if (!own) begin
         if (|req) begin
            nxt      = ((&req) ? ~last_owner : req[1]) ? OWN1 : OWN0;
            nxt_hold = '0;
         end
      end else if (req[cur] & lock[cur] & (hold_cnt < HOLD_LIM)) begin
         nxt_hold = hold_cnt + 1'b1;
      end else begin
         nxt_hold = '0;
         if (req[~cur]) begin
            nxt      = cur ? OWN0 : OWN1;
            nxt_last = cur;
         end else if (!req[cur]) begin
            nxt      = IDLE;
            nxt_last = cur;
         end
      end
   end
   // rvalid one-hot doubles as the registered read owner, so it follows the issuer after a grant swap
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         gnt        <= '0;
         hold_cnt   <= '0;
         last_owner <= 1'b1;
         rvalid     <= '0;
      end else begin
         state      <= nxt;
         gnt        <= {nxt == OWN1, nxt == OWN0};
         hold_cnt   <= nxt_hold;
         last_owner <= nxt_last;
         rvalid     <= rd_s ? (cur ? 2'b10 : 2'b01) : 2'b00;
      end
   end
endmodule

// File: tb/tb_ahb_slave_mem_arb.sv
// tb_ahb_slave_mem_arb: directed spec scenarios plus random traffic against a
// tenure-counting reference model of the arbiter.
module tb_ahb_slave_mem_arb;
   localparam int AB = 24, DB = 32, MH = 4;
   logic clk = 1'b0, reset = 1'b0;
   always #5 clk = ~clk;
   logic [1:0]    req, lock, wr;
   logic [AB-1:0] addr [2];
   logic [3:0]    bsel [2];
   logic [DB-1:0] din  [2];
   logic [DB-1:0] dout_mem;
   ahb_slave_mem_arb_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();
   ahb_slave_mem_arb #(.ADDR_BITS(AB), .DATA_BITS(DB), .MAX_HOLD(MH)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   assign bus.m0_req  = req[0];
   assign bus.m1_req  = req[1];
   assign bus.m0_lock = lock[0];
   assign bus.m1_lock = lock[1];
   assign bus.m0_wr   = wr[0];
   assign bus.m1_wr   = wr[1];
   assign bus.m0_addr = addr[0];
   assign bus.m1_addr = addr[1];
   assign bus.m0_bsel = bsel[0];
   assign bus.m1_bsel = bsel[1];
   assign bus.m0_din  = din[0];
   assign bus.m1_din  = din[1];
   assign bus.DOUT    = dout_mem;
   int checks = 0, errors = 0;
   int own = -1, last = 1, cnt = 0, rv = -1;
   bit known = 0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // model: owner/last-owner/accesses-this-tenure, plus which port awaits read data
   task automatic tick();
      int  o;
      bit  acc, w, r;
      #1;
      o   = (own < 0) ? 0 : own;
      acc = (own >= 0) && req[o];
      w   = acc && wr[o];
      r   = acc && !wr[o];
      if (known) begin
         chk("gnt0", bus.m0_gnt, own == 0);
         chk("gnt1", bus.m1_gnt, own == 1);
         chk("wr", bus.WR, w);
         chk("rd", bus.RD, r);
         chk("addr_wr", bus.ADDR_WR, w ? 64'(addr[o]) : 64'd0);
         chk("addr_rd", bus.ADDR_RD, r ? 64'(addr[o]) : 64'd0);
         chk("bsel", bus.BSEL, w ? 64'(bsel[o]) : 64'd0);
         chk("din", bus.DIN, w ? 64'(din[o]) : 64'd0);
         chk("rvalid0", bus.m0_rvalid, rv == 0);
         chk("rvalid1", bus.m1_rvalid, rv == 1);
         chk("dout0", bus.m0_dout, (rv == 0) ? 64'(dout_mem) : 64'd0);
         chk("dout1", bus.m1_dout, (rv == 1) ? 64'(dout_mem) : 64'd0);
      end
      @(posedge clk);
      if (!reset) begin
         own = -1; last = 1; cnt = 0; rv = -1; known = 1;
      end else if (known) begin
         rv = r ? o : -1;
         if (own < 0) begin
            if (req != 2'b00) begin
               own = (req == 2'b11) ? 1 - last : (req[0] ? 0 : 1);
               cnt = 0;
            end
         end else begin
            if (acc) cnt++;
            if (!(req[o] && lock[o] && cnt < MH)) begin
               cnt = 0;
               if (req[1-o]) begin own = 1 - o; last = o; end
               else if (!req[o]) begin own = -1; last = o; end
            end
         end
      end
      @(negedge clk);
   endtask
   initial begin
      int n0, n1, idle, n;
      req = '0; lock = '0; wr = '0; dout_mem = '0;
      for (int k = 0; k < 2; k++) begin addr[k] = '0; bsel[k] = '0; din[k] = '0; end
      @(negedge clk);
      req = 2'b11;
      repeat (3) tick();
      #1;
      chk("rst_gnt", {bus.m1_gnt, bus.m0_gnt}, 0);
      chk("rst_strobe", {bus.WR, bus.RD}, 0);
      chk("rst_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 0);
      reset = 1'b1;
      tick();
      #1 chk("first_gnt0", {bus.m1_gnt, bus.m0_gnt}, 2'b01);
      req = 2'b00;
      repeat (2) tick();
      req = 2'b10; wr = 2'b10; addr[1] = 24'h10; bsel[1] = 4'b0011; din[1] = 32'hA5A5_1234;
      tick();
      #1;
      chk("sw_gnt1", bus.m1_gnt, 1);
      chk("sw_wr", bus.WR, 1);
      chk("sw_addr", bus.ADDR_WR, 24'h10);
      chk("sw_bsel", bus.BSEL, 4'b0011);
      chk("sw_din", bus.DIN, 32'hA5A5_1234);
      tick();
      req = 2'b00; wr = 2'b00;
      repeat (2) tick();
      req = 2'b01; addr[0] = 24'h20;
      tick();
      #1;
      chk("rr_rd", bus.RD, 1);
      chk("rr_addr", bus.ADDR_RD, 24'h20);
      tick();
      req = 2'b00; dout_mem = 32'hDEAD_BEEF;
      #1;
      chk("rr_rvalid0", bus.m0_rvalid, 1);
      chk("rr_dout0", bus.m0_dout, 32'hDEAD_BEEF);
      chk("rr_rvalid1", bus.m1_rvalid, 0);
      repeat (2) tick();
      req = 2'b11; n0 = 0; n1 = 0; idle = 0;
      tick();
      for (int i = 0; i < 8; i++) begin
         #1;
         n0 += int'(bus.m0_gnt && (bus.WR || bus.RD));
         n1 += int'(bus.m1_gnt && (bus.WR || bus.RD));
         idle += int'(!(bus.WR || bus.RD));
         tick();
      end
      chk("rr_n0", n0, 4);
      chk("rr_n1", n1, 4);
      chk("rr_idle", idle, 0);
      req = 2'b00;
      repeat (2) tick();
      req = 2'b01; lock = 2'b01;
      tick();
      req = 2'b11; n = 0;
      for (int i = 0; i < 20 && !bus.m1_gnt; i++) begin
         #1 n += int'(bus.m0_gnt && (bus.WR || bus.RD));
         tick();
      end
      chk("hold_n0", n, MH);
      chk("hold_gnt1", bus.m1_gnt, 1);
      req = 2'b00; lock = 2'b00;
      repeat (2) tick();
      req = 2'b10; addr[1] = 24'h5;
      tick();
      #1 chk("mid_rd", bus.RD, 1);
      reset = 1'b0;
      tick();
      #1;
      chk("mid_rvalid1", bus.m1_rvalid, 0);
      chk("mid_gnt", {bus.m1_gnt, bus.m0_gnt}, 0);
      reset = 1'b1; req = 2'b00;
      tick();
      for (int i = 0; i < 1500; i++) begin
         for (int k = 0; k < 2; k++) begin
            req[k]  = ($urandom % 10) < 7;
            lock[k] = $urandom % 2;
            wr[k]   = $urandom % 2;
            addr[k] = AB'($urandom);
            bsel[k] = 4'($urandom);
            din[k]  = $urandom;
         end
         dout_mem = $urandom;
         reset = ($urandom % 100) != 0;
         tick();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
